edge_event_array: RTL
=====================

EDGE_EVENT_ARRAY -- requirements
Module: edge_event_array

Interface
REQ-001 The module SHALL have parameter NCH, default 7, meaning the number of independent input channels (1..32).
REQ-002 The module SHALL have parameter SYNC_STAGES, default 2, meaning the synchroniser flop depth per channel (>=2).
REQ-003 The module SHALL have parameter DB_CYCLES, default 4, meaning the consecutive-cycle stability required before a level change is accepted (1..255).
REQ-004 Port clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-005 Port rst  input  1  SHALL be the reset, synchronous and active-high.
REQ-006 Port en  input  1  SHALL be the global detect enable.
REQ-007 Port sig_i  input  NCH  SHALL carry the raw, possibly asynchronous, channel inputs.
REQ-008 Port mode_i  input  2*NCH  SHALL select the per-channel edge mode, bits [2i+1:2i] for channel i: 00 off, 01 rising, 10 falling, 11 both.
REQ-009 Port clear_i  input  NCH  SHALL clear the per-channel pending flags.
REQ-010 Port level_o  output  NCH  SHALL present the debounced level per channel.
REQ-011 Port pulse_o  output  NCH  SHALL present a one-cycle qualified edge pulse per channel.
REQ-012 Port pending_o  output  NCH  SHALL present a sticky per-channel event flag.
REQ-013 Port any_o  output  1  SHALL be the OR-reduction of pending_o.

Function
REQ-014 Each channel SHALL pass sig_i[i] through a SYNC_STAGES-deep flop chain; sync[i] denotes the last stage.
REQ-015 Each channel SHALL own a debounce counter of width clog2(DB_CYCLES+1).
REQ-016 When en=1 and sync[i]==level_o[i], cnt[i] SHALL be 0 at the next edge.
REQ-017 When en=1, sync[i]!=level_o[i] and cnt[i]<DB_CYCLES-1, cnt[i] SHALL increment.
REQ-018 When en=1, sync[i]!=level_o[i] and cnt[i]==DB_CYCLES-1, level_o[i] SHALL take sync[i] and cnt[i] SHALL go to 0 (accept edge).
REQ-019 On an accept edge, pulse_o[i] SHALL be 1 for exactly the following cycle if the mode sampled at that edge matches the direction (01 for 0->1, 10 for 1->0, 11 for either); otherwise pulse_o[i] SHALL be 0.
REQ-020 Mode 00 SHALL still update level_o[i] but SHALL produce no pulse and no pending set.
REQ-021 A sig_i change stable before edge 0 SHALL appear on level_o/pulse_o after edge SYNC_STAGES+DB_CYCLES-1 (edge 5 with defaults).
REQ-022 A mismatch at sync[i] lasting fewer than DB_CYCLES consecutive cycles SHALL NOT change level_o[i] or assert pulse_o[i].
REQ-023 When en=0, the sync chains SHALL keep running, all cnt SHALL be 0, level_o SHALL hold, and pulse_o SHALL be 0; pending_o SHALL hold except for clears.
REQ-024 On re-enable, any sync/level mismatch SHALL debounce from cnt=0 per REQ-017/018.
REQ-025 pending_o[i] SHALL set on the edge pulse_o[i] is driven to 1 and clear on an edge with clear_i[i]=1; set and clear on the same edge SHALL leave pending_o[i]=1.
REQ-026 Channels SHALL be fully independent; simultaneous accepts on several channels SHALL each pulse in the same cycle.
REQ-027 any_o SHALL be combinational from pending_o (no added latency).

Reset
REQ-028 With rst=1 at an edge, all sync flops, cnt, level_o, pulse_o and pending_o SHALL be 0, overriding en, clear_i and any in-progress debounce.
REQ-029 A channel held high through reset SHALL, after deassertion, be accepted as a rising edge per REQ-021 (pulse if mode 01/11).
REQ-030 Reset asserted mid-debounce SHALL discard the partial count; no pulse SHALL issue for that transition unless it restarts per REQ-029.

Verification
REQ-031 Defaults, mode=01 on ch0, en=1, sig_i[0] 0->1 before edge 0 and held: level_o[0]=1 and pulse_o[0]=1 after edge 5, pulse_o[0]=0 after edge 6, pending_o[0]=1, any_o=1.
REQ-032 Glitch: sig_i[0] high for 3 cycles then low: level_o[0], pulse_o[0], pending_o[0] remain 0 throughout.
REQ-033 Mode 10 on ch3: 0->1 gives level_o[3]=1 with no pulse; subsequent 1->0 gives one pulse; mode 11 pulses on both edges.
REQ-034 clear_i[0]=1 on the same edge pulse_o[0] is driven high: pending_o[0]=1 after; clear_i[0]=1 one cycle later: pending_o[0]=0, any_o=0.
REQ-035 en=0 while sig_i[1] toggles 0->1: no pulse, level_o[1]=0; raise en: pulse_o[1] exactly DB_CYCLES edges later.
REQ-036 rst=1 at edge 3 of a debounce in progress: all outputs 0 after that edge; with sig_i[0] still 1 after release, single pulse at edge 5 relative to the first edge with rst=0.

Source files
------------

// File: rtl/edge_event_array.sv
// edge_event_array: per-channel synchroniser, debouncer and qualified edge detector
// with sticky pending flags and a combined any flag.
module edge_event_array #(
    parameter int NCH         = 7,
    parameter int SYNC_STAGES = 2,
    parameter int DB_CYCLES   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [NCH-1:0]   sig_i,
    input  logic [2*NCH-1:0] mode_i,
    input  logic [NCH-1:0]   clear_i,
    output logic [NCH-1:0]   level_o,
    output logic [NCH-1:0]   pulse_o,
    output logic [NCH-1:0]   pending_o,
    output logic             any_o
);
    localparam int CW = $clog2(DB_CYCLES + 1);
    localparam logic [CW-1:0] CMAX = CW'(DB_CYCLES - 1);
    logic [NCH-1:0] sync_q [SYNC_STAGES];
    logic [CW-1:0]  cnt_q [NCH];
    logic [CW-1:0]  cnt_d [NCH];
    logic [NCH-1:0] sync;
    logic [NCH-1:0] level_q, level_d, pulse_q, pulse_d, pending_q, pending_d;
    assign sync = sync_q[SYNC_STAGES-1];
    always_comb begin
        level_d = level_q;
        pulse_d = '0;
        for (int i = 0; i < NCH; i++) begin
            cnt_d[i] = '0;
            if (en && sync[i] != level_q[i]) begin
                if (cnt_q[i] == CMAX) begin
                    level_d[i] = sync[i];
                    // mode bit 0 qualifies rising edges, bit 1 falling edges
                    pulse_d[i] = sync[i] ? mode_i[2*i] : mode_i[2*i+1];
                end else begin
                    cnt_d[i] = cnt_q[i] + CW'(1);
                end
            end
        end
        pending_d = pulse_d | (pending_q & ~clear_i);
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
            for (int i = 0; i < NCH; i++) cnt_q[i] <= '0;
            level_q   <= '0;
            pulse_q   <= '0;
            pending_q <= '0;
        end else begin
            sync_q[0] <= sig_i;
            for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
            for (int i = 0; i < NCH; i++) cnt_q[i] <= cnt_d[i];
            level_q   <= level_d;
            pulse_q   <= pulse_d;
            pending_q <= pending_d;
        end
    end
    assign level_o   = level_q;
    assign pulse_o   = pulse_q;
    assign pending_o = pending_q;
    assign any_o     = |pending_q;
endmodule
